// File: rtl/projectile_scheduler.sv
// ---------------------------------------------------------------------------
// projectile_scheduler
//
// Owns the shared pool of projectile slots. Fire requests from the player and
// the enemy fleet are arbitrated into free slots, one allocation per clock.
// Every live projectile advances on each game step strobe. A slot retires when
// it leaves the playfield or when the collision logic kills it.
//
// Ports
//   clk_master        system clock, all state on the rising edge
//   rst               synchronous, active-high reset
//   pulse_stepCycle   one-cycle game step strobe
//   fireReq_player    level request from the player controller
//   playerX/Y/W       player left edge, top edge, width (spawn position source)
//   fireReq_enemy     level request from the enemy fleet
//   enemyX/Y          enemy spawn position
//   hitClear          per-slot kill from the collision logic
//   slotValid         slot live
//   slotDir           1 = moving up (player shot), 0 = moving down (enemy shot)
//   slotX             slot i X at [10i+9:10i]
//   slotY             slot i Y at [9i+8:9i]
//   fireGrant_player  one-cycle grant pulse for the player
//   fireGrant_enemy   one-cycle grant pulse for the enemy fleet
//
// Request/grant handshake: a request is a level that is sampled on every
// rising edge. When it wins arbitration at edge N, the matching grant is high
// for cycle N+1 only. From that same cycle the slot outputs show the new
// projectile. The requester must drop its request once it sees the grant. A
// request that is still held is treated as a new request. A request that loses
// arbitration, or finds no free slot, stays pending without further action.
// ---------------------------------------------------------------------------
module projectile_scheduler #(
   parameter int NSLOTS          = 4,
   parameter int SCREEN_H        = 480,
   parameter int PROJ_SPEED      = 4,
   parameter int PLAYER_COOLDOWN = 8
) (
   input  logic                   clk_master,
   input  logic                   rst,
   input  logic                   pulse_stepCycle,
   input  logic                   fireReq_player,
   input  logic [9:0]             playerX,
   input  logic [8:0]             playerY,
   input  logic [9:0]             playerW,
   input  logic                   fireReq_enemy,
   input  logic [9:0]             enemyX,
   input  logic [8:0]             enemyY,
   input  logic [NSLOTS-1:0]      hitClear,
   output logic [NSLOTS-1:0]      slotValid,
   output logic [NSLOTS-1:0]      slotDir,
   output logic [10*NSLOTS-1:0]   slotX,
   output logic [9*NSLOTS-1:0]    slotY,
   output logic                   fireGrant_player,
   output logic                   fireGrant_enemy
);

   localparam int IDX_W = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
   localparam int CD_W  = $clog2(PLAYER_COOLDOWN + 1);

   localparam logic [9:0]      SPEED_10  = 10'(PROJ_SPEED);
   localparam logic [8:0]      SPEED_9   = 9'(PROJ_SPEED);
   localparam logic [9:0]      SCREEN_10 = 10'(SCREEN_H);
   localparam logic [CD_W-1:0] CD_LOAD   = CD_W'(PLAYER_COOLDOWN);

   // Slot state
   logic [NSLOTS-1:0] valid_q, valid_d;
   logic [NSLOTS-1:0] dir_q, dir_d;
   logic [9:0]        x_q [NSLOTS];
   logic [9:0]        x_d [NSLOTS];
   logic [8:0]        y_q [NSLOTS];
   logic [8:0]        y_d [NSLOTS];

   // Arbitration state
   logic [CD_W-1:0]   cooldown_q, cooldown_d;
   logic              ptr_enemy_q, ptr_enemy_d;   // 0 = player favoured on a tie
   logic              grant_player_q, grant_player_d;
   logic              grant_enemy_q, grant_enemy_d;

   // Combinational helpers
   logic              free_found;
   logic [IDX_W-1:0]  free_idx;
   logic              player_live;
   logic              player_elig;
   logic              enemy_elig;
   logic              alloc;
   logic [9:0]        player_spawn_x;

   // Find the lowest free slot. The search uses only the registered valid bits.
   // A slot that is freed this cycle therefore becomes allocatable one cycle later.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NSLOTS - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      player_live    = |(valid_q & dir_q);
      player_elig    = fireReq_player && (cooldown_q == '0) && !player_live;
      enemy_elig     = fireReq_enemy;
      player_spawn_x = playerX + (playerW >> 1);

      grant_player_d = free_found && player_elig && (!enemy_elig || !ptr_enemy_q);
      grant_enemy_d  = free_found && enemy_elig && (!player_elig || ptr_enemy_q);
      alloc          = grant_player_d || grant_enemy_d;

      // After a grant, the next tie is decided in favour of the other requester.
      ptr_enemy_d = ptr_enemy_q;
      if (grant_player_d) begin
         ptr_enemy_d = 1'b1;
      end else if (grant_enemy_d) begin
         ptr_enemy_d = 1'b0;
      end

      cooldown_d = cooldown_q;
      if (grant_player_d) begin
         cooldown_d = CD_LOAD;
      end else if (pulse_stepCycle && (cooldown_q != '0)) begin
         cooldown_d = cooldown_q - 1'b1;
      end
   end

   // Per-slot update. Each slot is handled in this order: new allocation, then
   // kill, then step. A newly allocated slot was invalid, so a kill or a step in
   // the same cycle cannot apply to it.
   always_comb begin
      valid_d = valid_q;
      dir_d   = dir_q;
      for (int i = 0; i < NSLOTS; i++) begin
         x_d[i] = x_q[i];
         y_d[i] = y_q[i];
         if (alloc && (free_idx == IDX_W'(i))) begin
            valid_d[i] = 1'b1;
            if (grant_player_d) begin
               dir_d[i] = 1'b1;
               x_d[i]   = player_spawn_x;
               y_d[i]   = playerY;
            end else begin
               dir_d[i] = 1'b0;
               x_d[i]   = enemyX;
               y_d[i]   = enemyY;
            end
         end else if (valid_q[i] && hitClear[i]) begin
            valid_d[i] = 1'b0;
         end else if (valid_q[i] && pulse_stepCycle) begin
            if (dir_q[i]) begin
               if (y_q[i] < SPEED_9) begin
                  valid_d[i] = 1'b0;
               end else begin
                  y_d[i] = y_q[i] - SPEED_9;
               end
            end else begin
               // The sum is formed at 10 bits, so a Y near 511 cannot wrap
               // and look as if it were still on screen.
               if (({1'b0, y_q[i]} + SPEED_10) >= SCREEN_10) begin
                  valid_d[i] = 1'b0;
               end else begin
                  y_d[i] = y_q[i] + SPEED_9;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_master) begin
      if (rst) begin
         valid_q        <= '0;
         dir_q          <= '0;
         cooldown_q     <= '0;
         ptr_enemy_q    <= 1'b0;
         grant_player_q <= 1'b0;
         grant_enemy_q  <= 1'b0;
         for (int i = 0; i < NSLOTS; i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
         end
      end else begin
         valid_q        <= valid_d;
         dir_q          <= dir_d;
         cooldown_q     <= cooldown_d;
         ptr_enemy_q    <= ptr_enemy_d;
         grant_player_q <= grant_player_d;
         grant_enemy_q  <= grant_enemy_d;
         for (int i = 0; i < NSLOTS; i++) begin
            x_q[i] <= x_d[i];
            y_q[i] <= y_d[i];
         end
      end
   end

   assign slotValid        = valid_q;
   assign slotDir          = dir_q;
   assign fireGrant_player = grant_player_q;
   assign fireGrant_enemy  = grant_enemy_q;

   for (genvar g = 0; g < NSLOTS; g++) begin : g_pack
      assign slotX[10*g +: 10] = x_q[g];
      assign slotY[9*g +: 9]   = y_q[g];
   end

endmodule

// File: tb/tb_projectile_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for projectile_scheduler. A behavioural model of the slot pool is
// evaluated on every rising edge. It pushes the outputs it expects for the
// following cycle into exp_q. One cycle later those values are compared with
// the DUT outputs. Directed scenarios also compare against fixed values.
// ---------------------------------------------------------------------------
module tb_projectile_scheduler;

   localparam int NSLOTS = 4;

   // ---------------- clock / reset ----------------
   logic clk_master = 1'b0;
   always #5 clk_master = ~clk_master;

   logic                 rst;
   logic                 pulse_stepCycle;
   logic                 fireReq_player;
   logic [9:0]           playerX;
   logic [8:0]           playerY;
   logic [9:0]           playerW;
   logic                 fireReq_enemy;
   logic [9:0]           enemyX;
   logic [8:0]           enemyY;
   logic [NSLOTS-1:0]    hitClear;
   logic [NSLOTS-1:0]    slotValid;
   logic [NSLOTS-1:0]    slotDir;
   logic [10*NSLOTS-1:0] slotX;
   logic [9*NSLOTS-1:0]  slotY;
   logic                 fireGrant_player;
   logic                 fireGrant_enemy;

   projectile_scheduler dut (
      .clk_master       (clk_master),
      .rst              (rst),
      .pulse_stepCycle  (pulse_stepCycle),
      .fireReq_player   (fireReq_player),
      .playerX          (playerX),
      .playerY          (playerY),
      .playerW          (playerW),
      .fireReq_enemy    (fireReq_enemy),
      .enemyX           (enemyX),
      .enemyY           (enemyY),
      .hitClear         (hitClear),
      .slotValid        (slotValid),
      .slotDir          (slotDir),
      .slotX            (slotX),
      .slotY            (slotY),
      .fireGrant_player (fireGrant_player),
      .fireGrant_enemy  (fireGrant_enemy)
   );

   // ---------------- scoreboard ----------------
   int check_count = 0;
   int pass_count  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      check_count++;
      if (obs === exp) pass_count++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   // Packed expectation: {gp, ge, valid[3:0], dir[3:0], x[39:0], y[35:0]}
   logic [85:0] exp_q[$];

   // ---------------- reference model ----------------
   bit m_valid [NSLOTS];
   bit m_dir   [NSLOTS];
   int m_x     [NSLOTS];
   int m_y     [NSLOTS];
   int m_cd;
   bit m_ptr_player;
   bit m_gp, m_ge;

   task automatic model_step();
      int free;
      bit plive, pe, ee, gp, ge;
      logic [85:0] e;
      if (rst) begin
         for (int i = 0; i < NSLOTS; i++) begin
            m_valid[i] = 0; m_dir[i] = 0; m_x[i] = 0; m_y[i] = 0;
         end
         m_cd = 0; m_ptr_player = 1; m_gp = 0; m_ge = 0;
      end else begin
         free = -1;
         plive = 0;
         for (int i = 0; i < NSLOTS; i++) begin
            if (!m_valid[i] && free < 0) free = i;
            if (m_valid[i] && m_dir[i]) plive = 1;
         end
         pe = fireReq_player && (m_cd == 0) && !plive;
         ee = fireReq_enemy;
         gp = 0; ge = 0;
         if (free >= 0) begin
            if (pe && ee) begin
               if (m_ptr_player) gp = 1; else ge = 1;
            end else begin
               gp = pe; ge = ee;
            end
         end
         for (int i = 0; i < NSLOTS; i++) begin
            if (i == free && (gp || ge)) begin
               m_valid[i] = 1;
               if (gp) begin
                  m_dir[i] = 1;
                  m_x[i]   = (int'(playerX) + int'(playerW) / 2) % 1024;
                  m_y[i]   = int'(playerY);
               end else begin
                  m_dir[i] = 0;
                  m_x[i]   = int'(enemyX);
                  m_y[i]   = int'(enemyY);
               end
            end else if (m_valid[i] && hitClear[i]) begin
               m_valid[i] = 0;
            end else if (m_valid[i] && pulse_stepCycle) begin
               if (m_dir[i]) begin
                  if (m_y[i] < 4) m_valid[i] = 0;
                  else m_y[i] = m_y[i] - 4;
               end else begin
                  if (m_y[i] + 4 >= 480) m_valid[i] = 0;
                  else m_y[i] = m_y[i] + 4;
               end
            end
         end
         if (gp) m_cd = 8;
         else if (pulse_stepCycle && m_cd > 0) m_cd = m_cd - 1;
         if (gp) m_ptr_player = 0;
         else if (ge) m_ptr_player = 1;
         m_gp = gp; m_ge = ge;
      end
      e = '0;
      e[85] = m_gp;
      e[84] = m_ge;
      for (int i = 0; i < NSLOTS; i++) begin
         e[80 + i]          = m_valid[i];
         e[76 + i]          = m_dir[i];
         e[36 + 10*i +: 10] = 10'(m_x[i]);
         e[9*i +: 9]        = 9'(m_y[i]);
      end
      exp_q.push_back(e);
   endtask

   task automatic compare_outputs();
      logic [85:0] e;
      e = exp_q.pop_front();
      check("grant_player", fireGrant_player, e[85]);
      check("grant_enemy",  fireGrant_enemy,  e[84]);
      check("slot_valid",   slotValid,        e[83:80]);
      check("slot_dir",     slotDir,          e[79:76]);
      check("slot_x",       slotX,            e[75:36]);
      check("slot_y",       slotY,            e[35:0]);
      check("grant_overlap", fireGrant_player & fireGrant_enemy, 1'b0);
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk_master);
      model_step();
      #1;
      compare_outputs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic do_step();
      pulse_stepCycle = 1'b1;
      tick();
      pulse_stepCycle = 1'b0;
   endtask

   task automatic fire_player();
      fireReq_player = 1'b1;
      tick();
      fireReq_player = 1'b0;
   endtask

   task automatic fire_enemy();
      fireReq_enemy = 1'b1;
      tick();
      fireReq_enemy = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; pulse_stepCycle = 1'b0;
      fireReq_player = 1'b0; fireReq_enemy = 1'b0;
      playerX = '0; playerY = '0; playerW = '0;
      enemyX = '0; enemyY = '0; hitClear = '0;

      do_reset();

      // Player fire and three steps
      playerX = 10'd100; playerW = 10'd20; playerY = 9'd440;
      fire_player();
      check("pf_grant", fireGrant_player, 1'b1);
      check("pf_valid0", slotValid[0], 1'b1);
      check("pf_x0", slotX[9:0], 10'd110);
      check("pf_y0", slotY[8:0], 9'd440);
      check("pf_dir0", slotDir[0], 1'b1);
      tick();
      check("pf_grant_once", fireGrant_player, 1'b0);
      for (int k = 0; k < 3; k++) begin
         do_step();
         tick();
      end
      check("pf_y_after3", slotY[8:0], 9'd428);

      // Reset with a projectile live
      do_reset();
      check("rst_valid", slotValid, 4'b0000);
      check("rst_dir", slotDir, 4'b0000);
      check("rst_x", slotX, 40'd0);
      check("rst_y", slotY, 36'd0);
      check("rst_grants", {fireGrant_player, fireGrant_enemy}, 2'b00);

      // Simultaneous requests right after reset
      enemyX = 10'd300; enemyY = 9'd50;
      fireReq_player = 1'b1; fireReq_enemy = 1'b1;
      tick();
      check("sim_gp", fireGrant_player, 1'b1);
      check("sim_ge0", fireGrant_enemy, 1'b0);
      fireReq_player = 1'b0;
      tick();
      check("sim_ge", fireGrant_enemy, 1'b1);
      check("sim_valid", slotValid, 4'b0011);
      check("sim_x1", slotX[19:10], 10'd300);
      check("sim_y1", slotY[17:9], 9'd50);
      fireReq_enemy = 1'b0;
      tick();

      // Full pool, then hitClear frees slot 2
      do_reset();
      enemyX = 10'd200; enemyY = 9'd100;
      fireReq_enemy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("fill_grant", fireGrant_enemy, 1'b1);
      end
      tick();
      check("full_no_grant", fireGrant_enemy, 1'b0);
      hitClear = 4'b0100;
      tick();
      hitClear = 4'b0000;
      check("hit_valid", slotValid, 4'b1011);
      check("hit_no_grant", fireGrant_enemy, 1'b0);
      tick();
      check("refill_grant", fireGrant_enemy, 1'b1);
      check("refill_valid", slotValid, 4'b1111);
      fireReq_enemy = 1'b0;
      tick();

      // Enemy at Y=474 near the bottom edge
      do_reset();
      enemyX = 10'd17; enemyY = 9'd474;
      fire_enemy();
      do_step();
      check("e474_y", slotY[8:0], 9'd478);
      check("e474_valid", slotValid[0], 1'b1);
      do_step();
      check("e474_retire", slotValid[0], 1'b0);
      check("e474_y_hold", slotY[8:0], 9'd478);

      // Player at Y=3 near the top edge
      do_reset();
      playerX = 10'd50; playerW = 10'd8; playerY = 9'd3;
      fire_player();
      do_step();
      check("p3_retire", slotValid[0], 1'b0);
      check("p3_y_hold", slotY[8:0], 9'd3);

      // Kill and step in the same cycle
      do_reset();
      enemyX = 10'd40; enemyY = 9'd100;
      fire_enemy();
      hitClear = 4'b0001;
      do_step();
      hitClear = 4'b0000;
      check("hitstep_valid", slotValid[0], 1'b0);
      check("hitstep_y", slotY[8:0], 9'd100);

      // Cooldown with the request held
      do_reset();
      playerX = 10'd200; playerW = 10'd16; playerY = 9'd400;
      fireReq_player = 1'b1;
      tick();
      check("cd_first_grant", fireGrant_player, 1'b1);
      hitClear = 4'b0001;
      tick();
      hitClear = 4'b0000;
      for (int k = 1; k <= 8; k++) begin
         do_step();
         check("cd_no_grant", fireGrant_player, 1'b0);
         if (k < 8) begin
            tick();
            check("cd_no_grant_idle", fireGrant_player, 1'b0);
         end
      end
      tick();
      check("cd_regrant", fireGrant_player, 1'b1);
      fireReq_player = 1'b0;
      tick();

      // Randomised traffic checked against the model
      do_reset();
      for (int n = 0; n < 2000; n++) begin
         rst             = ($urandom_range(0, 199) == 0);
         fireReq_player  = ($urandom_range(0, 3) == 0);
         fireReq_enemy   = ($urandom_range(0, 4) == 0);
         pulse_stepCycle = ($urandom_range(0, 2) == 0);
         hitClear        = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         playerX         = 10'($urandom_range(0, 1023));
         playerW         = 10'($urandom_range(0, 1023));
         playerY         = 9'($urandom_range(0, 511));
         enemyX          = 10'($urandom_range(0, 1023));
         enemyY          = 9'($urandom_range(0, 511));
         tick();
      end
      rst = 1'b0; fireReq_player = 1'b0; fireReq_enemy = 1'b0;
      pulse_stepCycle = 1'b0; hitClear = '0;
      tick();

      // ---------------- final report ----------------
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/projectile_scheduler.md
# projectile_scheduler

Owns the shared pool of projectile slots for the invaders game. Arbitrates fire requests from the player controller and the enemy fleet into a fixed number of slots. Advances every live projectile on each `pulse_stepCycle` and retires slots that leave the screen or are reported hit. It sits between the player/enemy controllers and the collision/render logic, which read its slot outputs.

## Interface
- `NSLOTS`, 4: number of projectile slots.
- `SCREEN_H`, 480: playfield height in pixels; valid Y is 0..SCREEN_H-1.
- `PROJ_SPEED`, 4: pixels moved per step pulse.
- `PLAYER_COOLDOWN`, 8: step pulses after a player grant before the player may fire again.

Ports:
- `clk_master`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pulse_stepCycle`  in  1  one-cycle game step strobe.
- `fireReq_player`  in  1  level request from the player.
- `playerX`  in  10  player left edge.
- `playerY`  in  9  player top edge.
- `playerW`  in  10  player width.
- `fireReq_enemy`  in  1  level request from the enemy fleet.
- `enemyX`  in  10  enemy spawn X.
- `enemyY`  in  9  enemy spawn Y.
- `hitClear`  in  NSLOTS  per-slot kill from collision logic.
- `slotValid`  out  NSLOTS  slot live.
- `slotDir`  out  NSLOTS  1 = moving up (player-owned), 0 = down (enemy).
- `slotX`  out  10*NSLOTS  slot i X at bits [10i+9:10i].
- `slotY`  out  9*NSLOTS  slot i Y at bits [9i+8:9i].
- `fireGrant_player`  out  1  one-cycle grant pulse.
- `fireGrant_enemy`  out  1  one-cycle grant pulse.

## Operation
- Reset: all `slotValid`, `slotDir`, `slotX` and `slotY` go to 0. Both grants go to 0, cooldown to 0, and the round-robin pointer favours the player. Reset overrides everything, including mid-flight projectiles.
- Player eligibility: `fireReq_player` high, cooldown == 0, and no valid slot with `slotDir` = 1. At most one player projectile is live.
- Enemy eligibility: `fireReq_enemy` high.
- Free slot: the lowest index with registered `slotValid` = 0, evaluated before this cycle's `hitClear` and retirements. A slot freed this cycle is allocatable next cycle.
- Allocation, at most one per cycle:
  - Only one requester eligible: it wins.
  - Both eligible: the pointer decides, and after a grant the pointer flips to the other requester.
  - No free slot: no grant; requests stay pending.
- Player spawn: X = `playerX` + (`playerW` >> 1), truncated to 10 bits; Y = `playerY`; dir = 1.
- Enemy spawn: X = `enemyX`, Y = `enemyY`, dir = 0.
- Player grant loads cooldown with `PLAYER_COOLDOWN`. Cooldown decrements by 1 on each `pulse_stepCycle` while nonzero.
- Step, per valid slot, on `pulse_stepCycle`:
  - Up: if Y < `PROJ_SPEED`, retire; else Y -= `PROJ_SPEED`.
  - Down: if Y + `PROJ_SPEED` >= `SCREEN_H`, retire; else Y += `PROJ_SPEED`. Compute the sum at 10 bits.
  - X is unchanged. Retire clears valid only; X, Y and dir hold their last values.
- Priority per slot: `rst` > `hitClear[i]` > step. `hitClear` on an invalid slot is ignored.
- A slot allocated this cycle is not stepped in the same cycle, even if `pulse_stepCycle` is high.
- Requesters must drop their request after seeing the grant. A held enemy request allocates again each cycle while slots remain free.

## Timing
- Requests and spawn coordinates are sampled at edge N. On a win, the grant is high for cycle N+1 only, and the slot outputs show the new projectile from N+1.
- Step and hit updates are visible on the cycle after the edge that sampled `pulse_stepCycle` or `hitClear`.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Throughput: one allocation per clock. A full pool blocks until a slot frees, then the grant comes one cycle after the slot's valid drops.

## Test plan
- Reset: hold `rst` for 2 cycles with projectiles live -> all outputs 0; first request after release is judged with the pointer on the player.
- Player fire: `playerX`=100, `playerW`=20, `playerY`=440, pulse request -> `fireGrant_player` high for one cycle, slot0 valid, X=110, Y=440, dir=1. After 3 step pulses, Y=428.
- Simultaneous requests after reset: `enemyX`=300, `enemyY`=50 -> player gets slot0 first, enemy gets slot1 on the next cycle, no cycle with both grants high.
- Full pool and hitClear: 4 enemy grants fill slots 0-3; a 5th request gets no grant; pulse `hitClear`=4'b0100 -> slot2 invalid the next cycle, enemy granted slot2 the cycle after.
- Boundaries:
  - Enemy at Y=474: first step gives Y=478 (still valid), second step retires it.
  - Player at Y=3: one step retires it.
  - `hitClear` and `pulse_stepCycle` in the same cycle on a slot -> the slot retires with Y unchanged.
- Cooldown: player shot killed by `hitClear` right after grant; request held -> no grant until the 8th step pulse has elapsed, then grant on the next cycle.
